// File: rtl/jam_param_solver.sv
// Exhaustive job-assignment solver: walks all N! worker->job permutations in lexicographic order
// against an external cost ROM. Optional macro JAM_BEST_PERM_EN adds the BestPerm output.
module jam_param_solver #(
  parameter int N          = 8,
  parameter int IDX_W      = 3,
  parameter int COST_W     = 7,
  parameter int SUM_W      = 10,
  parameter int CNT_W      = 4,
  parameter int AUTO_START = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  output logic [IDX_W-1:0]  W,
  output logic [IDX_W-1:0]  J,
  input  logic [COST_W-1:0] Cost,
  output logic [CNT_W-1:0]  MatchCount,
  output logic [SUM_W-1:0]  MinCost,
  output logic              Valid,
  output logic              BUSY
`ifdef JAM_BEST_PERM_EN
  ,
  output logic [N*IDX_W-1:0] BestPerm
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CMP,
    S_NEXT,
    S_DONE
  } state_t;

  state_t            state_reg;
  logic [IDX_W-1:0]  w_reg;
  logic [SUM_W-1:0]  acc_reg;
  logic [SUM_W-1:0]  best_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              auto_pending_reg;
  logic [IDX_W-1:0]  perm_reg [N];

  logic [SUM_W-1:0]  acc_sum;
  logic [CNT_W-1:0]  cnt_inc;
  logic [IDX_W-1:0]  j_sel;
  logic              last_w;
  logic              start_go;

  // next-permutation datapath
  logic              pivot_found;
  int                pivot;
  int                succ;
  logic [IDX_W-1:0]  piv_val;
  logic [IDX_W-1:0]  succ_val;
  logic [IDX_W-1:0]  swapped [N];
  logic [IDX_W-1:0]  next_perm [N];

  // Cost arrives one cycle after its address, so the final term is folded in during CMP.
  assign acc_sum = acc_reg + SUM_W'(Cost);
  assign cnt_inc = (&cnt_reg) ? cnt_reg : cnt_reg + CNT_W'(1);
  assign last_w  = (w_reg == IDX_W'(N - 1));

  assign start_go = ((state_reg == S_IDLE) &&
                     (START || ((AUTO_START != 0) && auto_pending_reg))) ||
                    ((state_reg == S_DONE) && START);

  always_comb begin
    j_sel = '0;
    for (int k = 0; k < N; k++) begin
      if (w_reg == IDX_W'(k)) begin
        j_sel = perm_reg[k];
      end
    end
  end

  always_comb begin
    pivot_found = 1'b0;
    pivot       = 0;
    succ        = 0;
    piv_val     = '0;
    succ_val    = '0;
    // Ascending scan: the last hit is the largest pivot index.
    for (int k = 0; k < N - 1; k++) begin
      if (perm_reg[k] < perm_reg[k+1]) begin
        pivot_found = 1'b1;
        pivot       = k;
      end
    end
    for (int k = 0; k < N; k++) begin
      if (k == pivot) begin
        piv_val = perm_reg[k];
      end
    end
    for (int k = 0; k < N; k++) begin
      if ((k > pivot) && (perm_reg[k] > piv_val)) begin
        succ     = k;
        succ_val = perm_reg[k];
      end
    end
    for (int k = 0; k < N; k++) begin
      if (k == pivot) begin
        swapped[k] = succ_val;
      end else if (k == succ) begin
        swapped[k] = piv_val;
      end else begin
        swapped[k] = perm_reg[k];
      end
    end
    // The suffix after the pivot is descending; reversing it yields the smallest tail.
    for (int k = 0; k < N; k++) begin
      next_perm[k] = swapped[k];
      for (int m = 0; m < N; m++) begin
        if ((k > pivot) && (m == N + pivot - k)) begin
          next_perm[k] = swapped[m];
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg        <= S_IDLE;
      w_reg            <= '0;
      acc_reg          <= '0;
      best_reg         <= '0;
      cnt_reg          <= '0;
      auto_pending_reg <= 1'b1;
      W                <= '0;
      J                <= '0;
      MatchCount       <= '0;
      MinCost          <= '0;
      Valid            <= 1'b0;
      BUSY             <= 1'b0;
      for (int k = 0; k < N; k++) begin
        perm_reg[k] <= IDX_W'(k);
      end
    end else if (start_go) begin
      state_reg        <= S_FETCH;
      w_reg            <= '0;
      acc_reg          <= '0;
      best_reg         <= '1;
      cnt_reg          <= '0;
      auto_pending_reg <= 1'b0;
      Valid            <= 1'b0;
      BUSY             <= 1'b1;
      for (int k = 0; k < N; k++) begin
        perm_reg[k] <= IDX_W'(k);
      end
    end else begin
      case (state_reg)
        S_FETCH: begin
          W       <= w_reg;
          J       <= j_sel;
          acc_reg <= (w_reg == '0) ? '0 : acc_sum;
          if (last_w) begin
            w_reg     <= '0;
            state_reg <= S_CMP;
          end else begin
            w_reg <= w_reg + IDX_W'(1);
          end
        end
        S_CMP: begin
          if (acc_sum < best_reg) begin
            best_reg <= acc_sum;
            cnt_reg  <= CNT_W'(1);
          end else if (acc_sum == best_reg) begin
            cnt_reg <= cnt_inc;
          end
          state_reg <= S_NEXT;
        end
        S_NEXT: begin
          if (pivot_found) begin
            for (int k = 0; k < N; k++) begin
              perm_reg[k] <= next_perm[k];
            end
            state_reg <= S_FETCH;
          end else begin
            state_reg <= S_DONE;
          end
        end
        S_DONE: begin
          MinCost    <= best_reg;
          MatchCount <= cnt_reg;
          Valid      <= 1'b1;
          BUSY       <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef JAM_BEST_PERM_EN
  logic [IDX_W-1:0] best_perm_reg     [N];
  logic [IDX_W-1:0] best_perm_out_reg [N];

  // Only a strict improvement moves the record, so the lexicographically first optimum is kept.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int k = 0; k < N; k++) begin
        best_perm_reg[k]     <= '0;
        best_perm_out_reg[k] <= '0;
      end
    end else if (!start_go) begin
      if ((state_reg == S_CMP) && (acc_sum < best_reg)) begin
        for (int k = 0; k < N; k++) begin
          best_perm_reg[k] <= perm_reg[k];
        end
      end
      if (state_reg == S_DONE) begin
        for (int k = 0; k < N; k++) begin
          best_perm_out_reg[k] <= best_perm_reg[k];
        end
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_best_perm
    assign BestPerm[gi*IDX_W +: IDX_W] = best_perm_out_reg[gi];
  end
`endif

endmodule

// File: tb/tb_jam_param_solver.sv
// Scoreboard bench for jam_param_solver at N=4: a brute-force model predicts each run's results,
// which are popped and compared when Valid rises.
module tb_jam_param_solver;

  localparam int N      = 4;
  localparam int IDX_W  = 3;
  localparam int COST_W = 7;
  localparam int SUM_W  = 10;
  localparam int CNT_W  = 4;
  localparam int RUN_LEN = 24 * (N + 2) + 1;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              START = 1'b0;
  logic [IDX_W-1:0]  W;
  logic [IDX_W-1:0]  J;
  logic [COST_W-1:0] Cost;
  logic [CNT_W-1:0]  MatchCount;
  logic [SUM_W-1:0]  MinCost;
  logic              Valid;
  logic              BUSY;
`ifdef JAM_BEST_PERM_EN
  logic [N*IDX_W-1:0] BestPerm;
`endif

  logic [COST_W-1:0] rom [16];
  int checks = 0;
  int passed = 0;

  typedef struct {
    int                 min_cost;
    int                 match;
    logic [N*IDX_W-1:0] perm;
  } exp_t;
  exp_t sb[$];

  always #5 CLK = ~CLK;

  assign Cost = rom[(int'(W) * N + int'(J)) % 16];

  jam_param_solver #(
    .N(N), .IDX_W(IDX_W), .COST_W(COST_W), .SUM_W(SUM_W), .CNT_W(CNT_W), .AUTO_START(1)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .START(START),
    .W(W),
    .J(J),
    .Cost(Cost),
    .MatchCount(MatchCount),
    .MinCost(MinCost),
    .Valid(Valid),
    .BUSY(BUSY)
`ifdef JAM_BEST_PERM_EN
    ,
    .BestPerm(BestPerm)
`endif
  );

  task automatic load_table(input int sel);
    int t3[16] = '{7, 3, 9, 2, 4, 8, 1, 6, 5, 2, 7, 3, 9, 6, 4, 8};
    for (int k = 0; k < 16; k++) begin
      case (sel)
        0:       rom[k] = COST_W'(t3[k]);
        1:       rom[k] = COST_W'(1);
        default: rom[k] = (k / 4 == k % 4) ? COST_W'(0) : COST_W'(50);
      endcase
    end
  endtask

  // Brute force in lexicographic order; strict < keeps the first optimum.
  function automatic exp_t model();
    exp_t e;
    int s;
    int d;
    e.min_cost = 1 << 30;
    e.match    = 0;
    e.perm     = '0;
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        if (b == a) continue;
        for (int c = 0; c < 4; c++) begin
          if (c == a || c == b) continue;
          d = 6 - a - b - c;
          s = int'(rom[a]) + int'(rom[4 + b]) + int'(rom[8 + c]) + int'(rom[12 + d]);
          if (s < e.min_cost) begin
            e.min_cost = s;
            e.match    = 1;
            e.perm     = {3'(d), 3'(c), 3'(b), 3'(a)};
          end else if (s == e.min_cost) begin
            e.match = (e.match < 15) ? e.match + 1 : 15;
          end
        end
      end
    end
    return e;
  endfunction

  task automatic push_expected();
    sb.push_back(model());
  endtask

  task automatic wait_valid(input int pulse_at, output int n);
    n = 0;
    do begin
      @(posedge CLK);
      #1;
      n++;
      START = (n == pulse_at);
    end while (!Valid && n < 1000);
    START = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    START = 1'b0;
    load_table(0);
    repeat (3) @(posedge CLK);
    #1;
    checks++; if (W !== 3'd0) $display("FAIL reset_W got %0d want 0", W); else passed++;
    checks++; if (J !== 3'd0) $display("FAIL reset_J got %0d want 0", J); else passed++;
    checks++; if (MatchCount !== 4'd0) $display("FAIL reset_MatchCount got %0d want 0", MatchCount); else passed++;
    checks++; if (MinCost !== 10'd0) $display("FAIL reset_MinCost got %0d want 0", MinCost); else passed++;
    checks++; if (Valid !== 1'b0) $display("FAIL reset_Valid got %b want 0", Valid); else passed++;
    checks++; if (BUSY !== 1'b0) $display("FAIL reset_BUSY got %b want 0", BUSY); else passed++;
  endtask

  task automatic test_t3_autostart();
    int exp_w[10] = '{0, 1, 2, 3, 3, 3, 0, 1, 2, 3};
    int exp_j[10] = '{0, 1, 2, 3, 3, 3, 0, 1, 3, 2};
    int n;
    exp_t e;
    load_table(0);
    push_expected();
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;
    checks++; if (BUSY !== 1'b1) $display("FAIL t3_busy_start got %b want 1", BUSY); else passed++;
    for (int k = 0; k < 10; k++) begin
      @(posedge CLK);
      #1;
      checks++;
      if (W !== IDX_W'(exp_w[k]) || J !== IDX_W'(exp_j[k]))
        $display("FAIL t3_addr[%0d] got W=%0d J=%0d want W=%0d J=%0d", k, W, J, exp_w[k], exp_j[k]);
      else passed++;
    end
    wait_valid(-1, n);
    n += 10;
    $display("run t3: cycles=%0d MinCost=%0d MatchCount=%0d", n, MinCost, MatchCount);
    checks++; if (n !== RUN_LEN) $display("FAIL t3_len got %0d want %0d", n, RUN_LEN); else passed++;
    checks++; if (BUSY !== 1'b0) $display("FAIL t3_busy_end got %b want 0", BUSY); else passed++;
    e = sb.pop_front();
    checks++; if (MinCost !== SUM_W'(e.min_cost)) $display("FAIL t3_MinCost got %0d want %0d", MinCost, e.min_cost); else passed++;
    checks++; if (MatchCount !== CNT_W'(e.match)) $display("FAIL t3_MatchCount got %0d want %0d", MatchCount, e.match); else passed++;
`ifdef JAM_BEST_PERM_EN
    checks++; if (BestPerm !== e.perm) $display("FAIL t3_BestPerm got %h want %h", BestPerm, e.perm); else passed++;
`endif
  endtask

  task automatic test_start_rerun(input int sel);
    int n;
    exp_t e;
    checks++; if (Valid !== 1'b1) $display("FAIL rerun%0d_valid_held got %b want 1", sel, Valid); else passed++;
    load_table(sel);
    push_expected();
    @(negedge CLK);
    START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    checks++; if (Valid !== 1'b0 || BUSY !== 1'b1) $display("FAIL rerun%0d_drop got Valid=%b BUSY=%b want 0 1", sel, Valid, BUSY); else passed++;
    wait_valid(-1, n);
    $display("run rerun%0d: cycles=%0d MinCost=%0d MatchCount=%0d", sel, n, MinCost, MatchCount);
    checks++; if (n !== RUN_LEN) $display("FAIL rerun%0d_len got %0d want %0d", sel, n, RUN_LEN); else passed++;
    e = sb.pop_front();
    checks++; if (MinCost !== SUM_W'(e.min_cost)) $display("FAIL rerun%0d_MinCost got %0d want %0d", sel, MinCost, e.min_cost); else passed++;
    checks++; if (MatchCount !== CNT_W'(e.match)) $display("FAIL rerun%0d_MatchCount got %0d want %0d", sel, MatchCount, e.match); else passed++;
`ifdef JAM_BEST_PERM_EN
    checks++; if (BestPerm !== e.perm) $display("FAIL rerun%0d_BestPerm got %h want %h", sel, BestPerm, e.perm); else passed++;
`endif
  endtask

  task automatic test_start_busy();
    int n;
    exp_t e;
    load_table(2);
    push_expected();
    @(negedge CLK);
    START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    wait_valid(20, n);
    $display("run start_busy: cycles=%0d MinCost=%0d MatchCount=%0d", n, MinCost, MatchCount);
    checks++; if (n !== RUN_LEN) $display("FAIL busy_len got %0d want %0d", n, RUN_LEN); else passed++;
    e = sb.pop_front();
    checks++; if (MinCost !== SUM_W'(e.min_cost)) $display("FAIL busy_MinCost got %0d want %0d", MinCost, e.min_cost); else passed++;
    checks++; if (MatchCount !== CNT_W'(e.match)) $display("FAIL busy_MatchCount got %0d want %0d", MatchCount, e.match); else passed++;
  endtask

  task automatic test_rst_midrun();
    int n;
    exp_t e;
    load_table(2);
    @(negedge CLK);
    START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    repeat (50) @(posedge CLK);
    #1;
    RST = 1'b1;
    #1;
    sb.delete();
    checks++; if (W !== 3'd0 || J !== 3'd0) $display("FAIL midrst_WJ got W=%0d J=%0d want 0 0", W, J); else passed++;
    checks++; if (MinCost !== 10'd0) $display("FAIL midrst_MinCost got %0d want 0", MinCost); else passed++;
    checks++; if (MatchCount !== 4'd0) $display("FAIL midrst_MatchCount got %0d want 0", MatchCount); else passed++;
    checks++; if (Valid !== 1'b0 || BUSY !== 1'b0) $display("FAIL midrst_flags got Valid=%b BUSY=%b want 0 0", Valid, BUSY); else passed++;
    push_expected();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;
    checks++; if (BUSY !== 1'b1) $display("FAIL midrst_autostart got BUSY=%b want 1", BUSY); else passed++;
    wait_valid(-1, n);
    $display("run midrst: cycles=%0d MinCost=%0d MatchCount=%0d", n, MinCost, MatchCount);
    checks++; if (n !== RUN_LEN) $display("FAIL midrst_len got %0d want %0d", n, RUN_LEN); else passed++;
    e = sb.pop_front();
    checks++; if (MinCost !== SUM_W'(e.min_cost)) $display("FAIL midrst_res_MinCost got %0d want %0d", MinCost, e.min_cost); else passed++;
    checks++; if (MatchCount !== CNT_W'(e.match)) $display("FAIL midrst_res_MatchCount got %0d want %0d", MatchCount, e.match); else passed++;
  endtask

  initial begin
    test_reset();
    test_t3_autostart();
    test_start_rerun(1);
    test_start_rerun(2);
    test_start_busy();
    test_start_rerun(0);
    test_rst_midrun();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
